// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and status flags.
// MUL runs a WIDTH-cycle shift-add and returns the full 2*WIDTH product.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   r_y;
  logic               r_c;
  logic               r_v;
  logic [2*WIDTH-1:0] nacc;
  logic               last;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

  always_comb begin
    r_y = '0;
    r_c = 1'b0;
    r_v = 1'b0;
    unique case (sel)
      OP_ADD: begin
        r_y = sum[WIDTH-1:0];
        r_c = sum[WIDTH];
        r_v = (a[WIDTH-1] == b[WIDTH-1]) &&
              (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r_y = diff[WIDTH-1:0];
        r_c = diff[WIDTH];
        r_v = (a[WIDTH-1] != b[WIDTH-1]) &&
              (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL:  r_y = '0;
      OP_NOT:  r_y = ~a;
      OP_AND:  r_y = a & b;
      OP_OR:   r_y = a | b;
      OP_XOR:  r_y = a ^ b;
      OP_XNOR: r_y = ~(a ^ b);
      default: r_y = '0;
    endcase
  end

  // One partial product per cycle, LSB of the multiplier first
  assign nacc = acc + (mplier[0] ? mcand : '0);
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      y      <= '0;
      y_hi   <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (sel == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              state  <= S_MUL;
            end else begin
              y     <= r_y;
              y_hi  <= '0;
              cout  <= r_c;
              ovf   <= r_v;
              zero  <= (r_y == '0);
              neg   <= r_y[WIDTH-1];
              state <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc    <= nacc;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            {y_hi, y} <= nacc;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= (nacc == '0);
            neg   <= nacc[2*WIDTH-1];
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param: directed vector table, handshake corner
// cases and random ops against an arithmetic reference model.
module tb_alu_seq_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [2:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic [W-1:0] y_hi;
  logic         cout;
  logic         zero;
  logic         neg;
  logic         ovf;

  int ncomp = 0;
  int nfail = 0;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .cout(cout),
    .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] y;
    logic [W-1:0] yh;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
    int           lat;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    ncomp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected {y, y_hi, cout, zero, neg, ovf} from plain integer arithmetic
  function automatic logic [2*W+3:0] model(input logic [2:0] s,
    input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    int ua, ub, sa, sb, r, sr;
    logic [W-1:0] yy, yh;
    logic c, v, z, n;
    ua = int'(ia); ub = int'(ib);
    sa = int'($signed(ia)); sb = int'($signed(ib));
    r = 0; yy = '0; yh = '0; c = 0; v = 0;
    case (s)
      3'd0: begin
        r = ua + ub + int'(ic); yy = W'(r); c = (r > 255);
        sr = sa + sb + int'(ic); v = (sr > 127) || (sr < -128);
      end
      3'd1: begin
        r = ua - ub - int'(ic); yy = W'(r); c = (r < 0);
        sr = sa - sb - int'(ic); v = (sr > 127) || (sr < -128);
      end
      3'd2: begin
        r = ua * ub; yy = W'(r); yh = W'(r >> W);
      end
      3'd3: yy = ~ia;
      3'd4: yy = ia & ib;
      3'd5: yy = ia | ib;
      3'd6: yy = ia ^ ib;
      default: yy = ~(ia ^ ib);
    endcase
    z = (s == 3'd2) ? (r == 0) : (yy == '0);
    n = (s == 3'd2) ? yh[W-1] : yy[W-1];
    return {yy, yh, c, z, n, v};
  endfunction

  task automatic run_op(input logic [2:0] s, input logic [W-1:0] ia,
    input logic [W-1:0] ib, input logic ic, input int hold,
    output logic [2*W+3:0] got, output int lat);
    int guard;
    logic busy_rdy;
    guard = 0;
    busy_rdy = 1'b0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    sel = s; a = ia; b = ib; cin = ic; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", 64'(out_valid), 64'd1);
    check("busy_in_ready", 64'(busy_rdy), 64'd0);
    got = {y, y_hi, cout, zero, neg, ovf};
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2*W+3:0] got;
    logic [2*W+3:0] snap;
    logic [2*W+3:0] exp;
    logic [2:0]     rs;
    logic [W-1:0]   ra, rb;
    logic           rc;
    logic           stale;
    int             lat;

    tbl[0]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[1]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[2]  = '{3'd1, 8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[3]  = '{3'd1, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[4]  = '{3'd1, 8'h05, 8'h05, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[5]  = '{3'd2, 8'hFF, 8'hFF, 1'b1, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 9};
    tbl[6]  = '{3'd2, 8'h00, 8'hC3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9};
    tbl[7]  = '{3'd3, 8'hA5, 8'h0F, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{3'd4, 8'hA5, 8'h0F, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[9]  = '{3'd5, 8'hA5, 8'h0F, 1'b1, 8'hAF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[10] = '{3'd6, 8'hA5, 8'h0F, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[11] = '{3'd7, 8'hA5, 8'h0F, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[12] = '{3'd0, 8'h7F, 8'h80, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[13] = '{3'd2, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 9};

    #1;
    check("reset_outputs",
          64'({out_valid, y, y_hi, cout, zero, neg, ovf}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].cin,
             i % 3, got, lat);
      exp = {tbl[i].y, tbl[i].yh, tbl[i].c, tbl[i].z, tbl[i].n, tbl[i].v};
      check($sformatf("vec%0d_result", i), 64'(got), 64'(exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
    end

    // Backpressure: result must hold and new requests must be ignored
    sel = 3'd0; a = 8'h7F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_valid", 64'(out_valid), 64'd1);
    snap = {y, y_hi, cout, zero, neg, ovf};
    check("bp_value", 64'(snap), 64'({8'h80, 8'h00, 4'b0011}));
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      sel = 3'(k + 4);
      a = W'($urandom);
      @(posedge clk); #1;
      check("bp_stable", 64'({y, y_hi, cout, zero, neg, ovf}), 64'(snap));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", 64'({in_ready, out_valid}), 64'b10);
    run_op(3'd4, 8'h3C, 8'hF0, 1'b0, 0, got, lat);
    check("bp_next_result", 64'(got), 64'(model(3'd4, 8'h3C, 8'hF0, 1'b0)));
    check("bp_next_latency", 64'(lat), 64'd1);

    // Reset during the 4th MUL cycle
    sel = 3'd2; a = 8'hFF; b = 8'hFF; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midmul_busy", 64'({in_ready, out_valid}), 64'b00);
    rst_n = 1'b0;
    #1;
    check("midmul_reset_outputs",
          64'({out_valid, y, y_hi, cout, zero, neg, ovf}), 64'd0);
    check("midmul_reset_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) stale = 1'b1;
    end
    check("midmul_no_stale", 64'(stale), 64'd0);
    run_op(3'd0, 8'h02, 8'h03, 1'b0, 0, got, lat);
    check("post_reset_add", 64'(got), 64'({8'h05, 8'h00, 4'b0000}));

    for (int k = 0; k < 150; k++) begin
      rs = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if (k % 10 == 0) ra = 8'hFF;
      if (k % 10 == 1) rb = 8'h80;
      run_op(rs, ra, rb, rc, int'($urandom_range(0, 2)), got, lat);
      check($sformatf("rnd%0d_op%0d_result", k, rs),
            64'(got), 64'(model(rs, ra, rb, rc)));
      check($sformatf("rnd%0d_latency", k), 64'(lat),
            64'((rs == 3'd2) ? W + 1 : 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
